// File: rtl/synth_cmd_pkg.sv
// rtl/synth_cmd_pkg.sv - note-command constants, MIDI status nibbles, parser states, command builder
package synth_cmd_pkg;

    localparam logic [31:0] CMD_STOP_ALL     = 32'h0000_7F00;
    localparam logic [6:0]  STOP_ALL_NOTE    = 7'h7F;

    localparam logic [3:0]  ST_NOTE_OFF      = 4'h8;
    localparam logic [3:0]  ST_NOTE_ON       = 4'h9;
    localparam logic [3:0]  ST_POLY_AT       = 4'hA;
    localparam logic [3:0]  ST_CTRL          = 4'hB;
    localparam logic [3:0]  ST_PROG          = 4'hC;
    localparam logic [3:0]  ST_CHAN_AT       = 4'hD;
    localparam logic [3:0]  ST_PITCH         = 4'hE;

    localparam logic [6:0]  CC_ALL_NOTES_OFF = 7'd123;
    localparam logic [6:0]  CC_ALL_SOUND_OFF = 7'd120;

    typedef enum logic [1:0] {
        NO_STATUS = 2'd0,
        WAIT_D1   = 2'd1,
        WAIT_D2   = 2'd2
    } parser_state_t;

    function automatic logic [31:0] cmd_word(input logic on, input logic [6:0] note,
                                             input logic [7:0] velocity);
        return {16'h0000, on, note, velocity};
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous command FIFO with full/empty/level
// Ports: clk, resetn (sync active-low), push/push_data, pop, head (entry at read pointer),
//        full, empty, level (0..DEPTH).
module cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign level   = count;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/midi_cmd_master.sv
// rtl/midi_cmd_master.sv - MIDI byte parser issuing Avalon-MM note-command writes
// Ports: s_byte_valid/s_byte_data/s_byte_ready (MIDI byte input), avm_m0_write/avm_m0_writedata/
//        avm_m0_waitrequest (Avalon master), o_fifo_level (queued commands incl. one on the bus),
//        reset (sync active-low).
// Option: `MIDI_CHANNEL_FILTER_EN restricts pushes to channel MIDI_CHANNEL.
module midi_cmd_master
    import synth_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int MIDI_CHANNEL = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_byte_valid,
    input  logic [7:0]                    s_byte_data,
    output logic                          s_byte_ready,
    output logic                          avm_m0_write,
    output logic [31:0]                   avm_m0_writedata,
    input  logic                          avm_m0_waitrequest,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        MIDI_CHANNEL < 0 || MIDI_CHANNEL > 15) begin : g_param_check
        $error("midi_cmd_master: invalid FIFO_DEPTH or MIDI_CHANNEL");
    end

    logic            fifo_full;
    logic            fifo_empty;
    logic [31:0]     fifo_head;
    logic [LW-1:0]   fifo_level;
    logic            push;
    logic [31:0]     push_word;
    logic            pop;
    logic            write_gap;

    parser_state_t   state;
    logic [3:0]      status_nib;
    logic [6:0]      d1;
    logic            foreign;
    logic            foreign_in;
    logic            accept;
    logic            is_data;
    logic            needs_d2;
    logic [6:0]      d2;

`ifdef MIDI_CHANNEL_FILTER_EN
    localparam logic [3:0] CHANNEL_NIB = 4'(MIDI_CHANNEL);
    assign foreign_in = (s_byte_data[3:0] != CHANNEL_NIB);
`else
    assign foreign_in = 1'b0;
`endif

    assign s_byte_ready = reset & ~fifo_full;
    assign accept       = s_byte_valid & s_byte_ready;
    assign is_data      = ~s_byte_data[7];
    assign d2           = s_byte_data[6:0];
    // Program change and channel pressure carry a single data byte.
    assign needs_d2     = (status_nib != ST_PROG) && (status_nib != ST_CHAN_AT);

    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (accept && is_data && state == WAIT_D2 && !foreign) begin
            case (status_nib)
                ST_NOTE_ON: begin
                    if (d2 != 7'd0) begin
                        push      = 1'b1;
                        push_word = cmd_word(1'b1, d1, {1'b0, d2});
                    end else if (d1 != STOP_ALL_NOTE) begin
                        push      = 1'b1;
                        push_word = cmd_word(1'b0, d1, 8'h00);
                    end
                end
                ST_NOTE_OFF: begin
                    // Note-off on 127 would alias STOP_ALL, so it is dropped.
                    if (d1 != STOP_ALL_NOTE) begin
                        push      = 1'b1;
                        push_word = cmd_word(1'b0, d1, 8'h00);
                    end
                end
                ST_CTRL: begin
                    if (d1 == CC_ALL_NOTES_OFF || d1 == CC_ALL_SOUND_OFF) begin
                        push      = 1'b1;
                        push_word = CMD_STOP_ALL;
                    end
                end
                default: begin
                    push      = 1'b0;
                    push_word = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= NO_STATUS;
            status_nib <= '0;
            d1         <= '0;
            foreign    <= 1'b0;
        end else if (accept && s_byte_data < 8'hF8) begin
            if (s_byte_data >= 8'hF0) begin
                state      <= NO_STATUS;
                status_nib <= '0;
                foreign    <= 1'b0;
            end else if (!is_data) begin
                state      <= WAIT_D1;
                status_nib <= s_byte_data[7:4];
                foreign    <= foreign_in;
            end else begin
                case (state)
                    WAIT_D1: begin
                        d1 <= d2;
                        if (needs_d2) state <= WAIT_D2;
                    end
                    WAIT_D2: state <= WAIT_D1;
                    default: state <= NO_STATUS;
                endcase
            end
        end
    end

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .resetn    (reset),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // One idle cycle after each completed write keeps the bus at most one write per two cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            write_gap <= 1'b0;
        end else begin
            write_gap <= pop;
        end
    end

    assign avm_m0_write     = reset & ~fifo_empty & ~write_gap;
    assign avm_m0_writedata = avm_m0_write ? fifo_head : 32'h0;
    assign pop              = avm_m0_write & ~avm_m0_waitrequest;
    assign o_fifo_level     = reset ? fifo_level : '0;

endmodule

// File: tb/tb_midi_cmd_master.sv
// tb/tb_midi_cmd_master.sv - scoreboard bench for midi_cmd_master
module tb_midi_cmd_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s_byte_valid = 1'b0;
    logic [7:0]  s_byte_data = 8'h00;
    logic        s_byte_ready;
    logic        avm_m0_write;
    logic [31:0] avm_m0_writedata;
    logic        avm_m0_waitrequest = 1'b0;
    logic [3:0]  o_fifo_level;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    midi_cmd_master #(
        .FIFO_DEPTH   (8),
        .MIDI_CHANNEL (0)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .s_byte_valid       (s_byte_valid),
        .s_byte_data        (s_byte_data),
        .s_byte_ready       (s_byte_ready),
        .avm_m0_write       (avm_m0_write),
        .avm_m0_writedata   (avm_m0_writedata),
        .avm_m0_waitrequest (avm_m0_waitrequest),
        .o_fifo_level       (o_fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] note_word(input logic on, input logic [6:0] n, input logic [7:0] v);
        return {16'h0000, on, n, v};
    endfunction

    // Monitor: every presented write must match the scoreboard head; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (avm_m0_write) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", avm_m0_writedata, 32'hFFFF_FFFF);
                end else begin
                    check("writedata", avm_m0_writedata, exp_q[0]);
                    if (!avm_m0_waitrequest) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        s_byte_valid = 1'b1;
        s_byte_data  = b;
        @(negedge clk);
        while (!s_byte_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!s_byte_ready) check("byte_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        s_byte_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || o_fifo_level != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check({name, "_queue_empty"}, exp_q.size(), 32'd0);
        check({name, "_level"}, {28'd0, o_fifo_level}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_write", {31'd0, avm_m0_write}, 32'd0);
        check("rst_writedata", avm_m0_writedata, 32'd0);
        check("rst_level", {28'd0, o_fifo_level}, 32'd0);
        check("rst_ready", {31'd0, s_byte_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, s_byte_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Basic note on / note off
        exp_q.push_back(32'h0000_C564);
        send_byte(8'h90); send_byte(8'h45); send_byte(8'h64);
        exp_q.push_back(32'h0000_4500);
        send_byte(8'h80); send_byte(8'h45); send_byte(8'h00);
        drain("basic");

        // Running status, velocity 0 as note off
        exp_q.push_back(32'h0000_BC64);
        exp_q.push_back(32'h0000_4000);
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        send_byte(8'h40); send_byte(8'h00);
        drain("running");

        // Controllers: 123 and 120 stop all, others ignored; note-off 127 dropped
        exp_q.push_back(32'h0000_7F00);
        send_byte(8'hB0); send_byte(8'h7B); send_byte(8'h00);
        exp_q.push_back(32'h0000_7F00);
        send_byte(8'h78); send_byte(8'h00);
        send_byte(8'h07); send_byte(8'h64);
        send_byte(8'h80); send_byte(8'h7F); send_byte(8'h40);
        drain("ctrl");

        // Real-time bytes interleaved; system byte clears running status
        exp_q.push_back(32'h0000_C564);
        send_byte(8'h90); send_byte(8'hF8); send_byte(8'h45);
        send_byte(8'hF8); send_byte(8'h64);
        send_byte(8'hF0); send_byte(8'h45); send_byte(8'h64);
        drain("sysrt");

        // Program change consumes one data byte per message; then note on vel 0
        send_byte(8'hC0); send_byte(8'h05); send_byte(8'h45);
        exp_q.push_back(32'h0000_2A00);
        send_byte(8'h90); send_byte(8'h2A); send_byte(8'h00);
        drain("prog");

        // Channel handling
`ifdef MIDI_CHANNEL_FILTER_EN
        send_byte(8'h91); send_byte(8'h45); send_byte(8'h64);
        exp_q.push_back(32'h0000_C564);
        send_byte(8'h90); send_byte(8'h45); send_byte(8'h64);
`else
        exp_q.push_back(32'h0000_C564);
        send_byte(8'h91); send_byte(8'h45); send_byte(8'h64);
`endif
        drain("channel");

        // Back-pressure: 10 notes with waitrequest held until the FIFO fills
        avm_m0_waitrequest = 1'b1;
        fork
            begin
                send_byte(8'h90);
                for (int i = 0; i < 10; i++) begin
                    exp_q.push_back(note_word(1'b1, 7'(8'h30 + i), 8'h7F));
                    send_byte(8'(8'h30 + i));
                    send_byte(8'h7F);
                end
            end
            begin
                int t;
                t = 0;
                while (o_fifo_level != 4'd8 && t < 1000) begin
                    @(negedge clk);
                    t++;
                end
                check("stall_level_full", {28'd0, o_fifo_level}, 32'd8);
                check("stall_ready_low", {31'd0, s_byte_ready}, 32'd0);
                repeat (5) @(negedge clk);
                check("stall_ready_still_low", {31'd0, s_byte_ready}, 32'd0);
                check("stall_write_held", {31'd0, avm_m0_write}, 32'd1);
                @(posedge clk);
                #1;
                avm_m0_waitrequest = 1'b0;
            end
        join
        drain("stall");

        // Reset mid-write drops the pending command and running status
        avm_m0_waitrequest = 1'b1;
        exp_q.push_back(32'h0000_B040);
        send_byte(8'h90); send_byte(8'h30); send_byte(8'h40);
        @(negedge clk);
        check("midwrite_write_high", {31'd0, avm_m0_write}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        avm_m0_waitrequest = 1'b0;
        @(negedge clk);
        check("after_rst_write", {31'd0, avm_m0_write}, 32'd0);
        check("after_rst_level", {28'd0, o_fifo_level}, 32'd0);
        @(posedge clk);
        #1;
        send_byte(8'h45); send_byte(8'h64);
        drain("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
